// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: op encodings, FSM states
// and the iteration counter width.
package mul_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULL = 2'b01;
  localparam logic [1:0] OP_SMULL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  localparam int MUL_DEF_WIDTH = 32;
  localparam int CNT_W         = cnt_width(MUL_DEF_WIDTH);

endpackage

// File: rtl/mul_shift_add_core.sv
// Shift-add datapath: magnitude operands, accumulator, iteration counter and final negate.
// MUL_EARLY_TERM_EN: end iterating once the remaining multiplier bits are all zero.
module mul_shift_add_core
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_DEF_WIDTH,
  parameter int CW    = CNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               last,
  output logic [2*WIDTH-1:0] acc
);

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [2*WIDTH-1:0] addend;

  always_comb begin
    addend = '0;
    if (mplier[0]) addend = {{WIDTH{1'b0}}, mcand} << cnt;
  end

  always_comb begin
`ifdef MUL_EARLY_TERM_EN
    last = (cnt == CW'(WIDTH-1)) || (mplier[WIDTH-1:1] == '0);
`else
    last = (cnt == CW'(WIDTH-1));
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= is_signed ? abs_val(src_a) : src_a;
      mplier <= is_signed ? abs_val(src_b) : src_b;
      neg    <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      cnt    <= '0;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc + addend;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end else if (fix && neg) begin
      acc    <= -acc;
    end
  end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative MUL/UMULL/SMULL unit: FSM, start/flush handshake and write-back address latches.
// MUL_EARLY_TERM_EN (see mul_shift_add_core) shortens CALC for small multipliers.
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       wa_lo,
  input  logic [3:0]       wa_hi,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             we_lo,
  output logic             we_hi,
  output logic [3:0]       wd_lo_addr,
  output logic [3:0]       wd_hi_addr
);

  state_e             state;
  state_e             state_nx;
  logic [1:0]         op_q;
  logic               accept;
  logic               last;
  logic [2*WIDTH-1:0] acc;

  assign accept = (state == S_IDLE) && start && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_CALC;
      S_CALC: begin
        if (flush)     state_nx = S_IDLE;
        else if (last) state_nx = S_FIX;
      end
      S_FIX:  state_nx = flush ? S_IDLE : S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_MUL;
      wd_lo_addr <= '0;
      wd_hi_addr <= '0;
    end else if (accept) begin
      op_q       <= op;
      wd_lo_addr <= wa_lo;
      wd_hi_addr <= wa_hi;
    end
  end

  mul_shift_add_core #(
    .WIDTH (WIDTH),
    .CW    (cnt_width(WIDTH))
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept),
    .step      ((state == S_CALC) && !flush),
    .fix       ((state == S_FIX) && !flush),
    .is_signed (op == OP_SMULL),
    .src_a     (src_a),
    .src_b     (src_b),
    .last      (last),
    .acc       (acc)
  );

  // MUL still presents the full upper half; only its write enable is suppressed.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign we_lo     = done;
  assign we_hi     = done && ((op_q == OP_UMULL) || (op_q == OP_SMULL));
  assign result_lo = acc[WIDTH-1:0];
  assign result_hi = acc[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_iter_unit.sv
// Self-checking bench for mul_iter_unit: behavioural latency/product model checked every
// cycle, plus directed vectors with literal expectations (both MUL_EARLY_TERM_EN builds).
module tb_mul_iter_unit;

  localparam int W = 32;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic [3:0]    wa_lo;
  logic [3:0]    wa_hi;
  logic          flush;
  logic          busy;
  logic          done;
  logic [W-1:0]  result_lo;
  logic [W-1:0]  result_hi;
  logic          we_lo;
  logic          we_hi;
  logic [3:0]    wd_lo_addr;
  logic [3:0]    wd_hi_addr;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  mul_iter_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .wa_lo      (wa_lo),
    .wa_hi      (wa_hi),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .we_lo      (we_lo),
    .we_hi      (we_hi),
    .wd_lo_addr (wd_lo_addr),
    .wd_hi_addr (wd_hi_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat_exp(input int full, input int early);
`ifdef MUL_EARLY_TERM_EN
    return early;
`else
    return full;
`endif
  endfunction

  // Product straight from the operation's arithmetic meaning.
  function automatic logic [63:0] model_prod(input logic [1:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint signed sp;
    logic [63:0]   ua;
    logic [63:0]   ub;
    if (o == 2'b10) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return sp;
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  // Cycles from the start edge to the done cycle, inclusive.
  function automatic int model_lat(input logic [1:0] o, input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    logic [W-1:0] m;
    int k;
    m = (o == 2'b10 && b[W-1]) ? -b : b;
    k = 1;
    for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
    return k + 2;
`else
    return W + 2;
`endif
  endfunction

  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_rem  = 0;
  logic [1:0]  m_op   = 2'b00;
  logic [63:0] m_prod = '0;
  bit          m_res_valid = 1;
  logic [3:0]  m_lo_addr = '0;
  logic [3:0]  m_hi_addr = '0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_rem = 0; m_op = 2'b00;
      m_prod = '0; m_res_valid = 1; m_lo_addr = '0; m_hi_addr = '0;
    end else if (!m_busy) begin
      if (start && !flush) begin
        m_busy = 1; m_done = 0;
        m_rem  = model_lat(op, src_b) - 1;
        m_op   = op;
        m_prod = model_prod(op, src_a, src_b);
        m_lo_addr = wa_lo; m_hi_addr = wa_hi;
        m_res_valid = 0;
      end
    end else if (m_done) begin
      m_busy = 0; m_done = 0;
    end else if (flush) begin
      m_busy = 0;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1;
        m_res_valid = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("we_lo", we_lo, m_done);
      chk("we_hi", we_hi, m_done && (m_op == 2'b01 || m_op == 2'b10));
      chk("wd_lo_addr", wd_lo_addr, m_lo_addr);
      chk("wd_hi_addr", wd_hi_addr, m_hi_addr);
      if (m_res_valid) begin
        chk("result_lo", result_lo, m_prod[31:0]);
        chk("result_hi", result_hi, m_prod[63:32]);
      end
    end
  end

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] lo_a, input logic [3:0] hi_a);
    @(negedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b; wa_lo = lo_a; wa_hi = hi_a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output int lat);
    lat = base;
    while (lat < 200) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] lo_a, input logic [3:0] hi_a, output int lat);
    start_op(o, a, b, lo_a, hi_a);
    wait_done(1, lat);
  endtask

  initial begin
    int lat;
    reset_n = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
    src_a = '0; src_b = '0; wa_lo = '0; wa_hi = '0;
    #1 reset_n = 1'b0;
    cmp_en = 1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", {result_hi, result_lo}, 64'h0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 4'd2, lat);
    chk("umull_lat", lat, lat_exp(34, 34));
    chk("umull_hi", result_hi, 32'hFFFFFFFE);
    chk("umull_lo", result_lo, 32'h00000001);
    chk("umull_we_hi", we_hi, 1);

    run_op(2'b10, 32'hFFFFFFFE, 32'h00000003, 4'd4, 4'd5, lat);
    chk("smull_neg_lat", lat, lat_exp(34, 4));
    chk("smull_neg", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFFA);

    run_op(2'b10, 32'h80000000, 32'h80000000, 4'd6, 4'd7, lat);
    chk("smull_min", {result_hi, result_lo}, 64'h40000000_00000000);

    run_op(2'b00, 32'h00010000, 32'h00010000, 4'd3, 4'd7, lat);
    chk("mul_lo", result_lo, 32'h0);
    chk("mul_hi", result_hi, 32'h1);
    chk("mul_we", {we_lo, we_hi}, 2'b10);
    chk("mul_addr", wd_lo_addr, 4'd3);
    // Flush during the DONE cycle must not disturb the write-back.
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_done_hold", {result_hi, result_lo}, 64'h00000001_00000000);

    // flush and start together in IDLE: start ignored.
    @(negedge clk); #1 start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", busy, 0);

    // A second start while busy is ignored.
    start_op(2'b01, 32'h00000007, 32'h80000009, 4'd6, 4'd8);
    repeat (5) @(negedge clk);
    #1 start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd100; wa_lo = 4'd15;
    @(posedge clk); #1 start = 1'b0;
    wait_done(0, lat);
    chk("ignore_start_res", {result_hi, result_lo}, 64'h00000003_8000003F);
    chk("ignore_start_addr", wd_lo_addr, 4'd6);

    // Flush part-way through CALC.
    start_op(2'b01, 32'h00001234, 32'hFFFFFFFF, 4'd2, 4'd3);
    repeat (9) @(negedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    repeat (40) @(negedge clk);

    // Asynchronous reset part-way through CALC.
    start_op(2'b10, 32'h7FFFFFFF, 32'h80000001, 4'd9, 4'd11);
    repeat (6) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", {result_hi, result_lo}, 64'h0);
    chk("arst_addr", {wd_hi_addr, wd_lo_addr}, 8'h00);
    @(negedge clk); #1 reset_n = 1'b1;

    run_op(2'b01, 32'h12345678, 32'h00000010, 4'd9, 4'd10, lat);
    chk("post_rst_lat", lat, lat_exp(34, 7));
    chk("post_rst_res", {result_hi, result_lo}, 64'h00000001_23456780);
    chk("post_rst_addr", {wd_hi_addr, wd_lo_addr}, 8'hA9);

    run_op(2'b00, 32'h0000DEAD, 32'h00000000, 4'd1, 4'd1, lat);
    chk("zero_b_lat", lat, lat_exp(34, 3));
    chk("zero_b_res", {result_hi, result_lo}, 64'h0);

    run_op(2'b00, 32'h11111111, 32'h00000005, 4'd2, 4'd2, lat);
    chk("b5_lat", lat, lat_exp(34, 5));
    chk("b5_lo", result_lo, 32'h55555555);

    run_op(2'b11, 32'hFFFFFFFF, 32'h00000002, 4'd4, 4'd12, lat);
    chk("op3_res", {result_hi, result_lo}, 64'h00000001_FFFFFFFE);
    chk("op3_we_hi", we_hi, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
